// File: rtl/lights_pkg.sv
// Shared types and timing defaults for the one-wire LED-stream transmitter and receiver.
package lights_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HIGH,
    HIGH,
    LOW,
    FLUSH
  } rx_state_e;

  localparam int unsigned BIT_CYCLES = 13;
  localparam int unsigned T1H        = 6;
  localparam int unsigned T0H        = 3;

  typedef struct packed {
    logic [17:0] adr;
    logic [15:0] wdata;
    logic [1:0]  sel;
  } wr_word_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lights_rx_sync.sv
// Two-flop synchronizer for the serial line with edge detection.
// LIGHTS_RX_GLITCH_FILTER_EN adds a registered 3-sample majority filter (+2 cycles latency).
module lights_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic sdin_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic line;

`ifdef LIGHTS_RX_GLITCH_FILTER_EN
  logic h0_q;
  logic h1_q;
  logic filt_q;

  // Majority delays both edges equally, so pulse widths are preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      h0_q   <= 1'b0;
      h1_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      h0_q   <= sync_q;
      h1_q   <= h0_q;
      filt_q <= (sync_q & h0_q) | (sync_q & h1_q) | (h0_q & h1_q);
    end
  end

  assign line = filt_q;
`else
  assign line = sync_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= line;
    end
  end

  assign sdin_o = line;
  assign rise_o = line & ~prev_q;
  assign fall_o = ~line & prev_q;

endmodule

// File: rtl/lights_receiver.sv
// Pulse-width-coded LED-stream decoder packing bytes into 16-bit bus writes.
// Optional LIGHTS_RX_GLITCH_FILTER_EN enables the majority filter in lights_rx_sync.
module lights_receiver
  import lights_pkg::*;
#(
  parameter int unsigned BASE_ADDR  = 500,
  parameter int unsigned MAX_BYTES  = 300,
  parameter int unsigned ONE_THRESH = 5,
  parameter int unsigned MAX_HIGH   = 10,
  parameter int unsigned MIN_HIGH   = 2,
  parameter int unsigned RESET_LOW  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        din,
  output logic [17:0] m_a_adr,
  output logic        m_a_req,
  input  logic        m_a_ack,
  output logic        m_a_write,
  output logic [1:0]  m_a_sel,
  input  logic [15:0] m_a_rdata,
  output logic [15:0] m_a_wdata,
  output logic        frame_done,
  output logic [8:0]  frame_bytes,
  output logic        err_overrun,
  output logic        err_timing
);

  localparam logic [7:0]  ONE_T  = 8'(ONE_THRESH);
  localparam logic [7:0]  MAX_H  = 8'(MAX_HIGH);
  localparam logic [7:0]  MIN_H  = 8'(MIN_HIGH);
  localparam logic [7:0]  RST_LO = 8'(RESET_LOW);
  localparam logic [8:0]  MAX_B  = 9'(MAX_BYTES);
  localparam logic [17:0] BASE   = 18'(BASE_ADDR);

  logic sdin, rise, fall;

  lights_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .din_i  (din),
    .sdin_o (sdin),
    .rise_o (rise),
    .fall_o (fall)
  );

  rx_state_e state_q, state_d;
  logic [7:0] hi_q, hi_d, lo_q, lo_d, lo_inc;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [6:0] shreg_q, shreg_d;
  logic [8:0] byte_idx_q, byte_idx_d;
  logic [7:0] lo_byte_q, lo_byte_d, byte_val;
  logic       frame_done_q, frame_done_d;
  logic [8:0] frame_bytes_q, frame_bytes_d;
  logic       err_timing_q, err_timing_d;
  logic       bit_vld, bit_val, abort;
  logic       push, can_push;
  wr_word_t   push_word;

  logic       out_vld_q, out_vld_d, req_q, req_d;
  logic       hold_vld_q, hold_vld_d;
  wr_word_t   out_q, out_d, hold_q, hold_d;
  logic       err_overrun_q, err_overrun_d;
  logic       ack_fire, slot_free;

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    bitcnt_d      = bitcnt_q;
    shreg_d       = shreg_q;
    byte_idx_d    = byte_idx_q;
    lo_byte_d     = lo_byte_q;
    frame_done_d  = 1'b0;
    frame_bytes_d = frame_bytes_q;
    err_timing_d  = err_timing_q;
    bit_vld       = 1'b0;
    bit_val       = 1'b0;
    abort         = 1'b0;
    push          = 1'b0;
    push_word     = '{adr: BASE + 18'(byte_idx_q[8:1]), wdata: 16'h0000, sel: 2'b11};
    lo_inc        = sat_inc8(lo_q);
    byte_val      = {shreg_q, bit_val};

    case (state_q)
      IDLE: begin
        if (sdin) begin
          lo_d = '0;
        end else if (lo_inc >= RST_LO) begin
          lo_d    = '0;
          state_d = WAIT_HIGH;
        end else begin
          lo_d = lo_inc;
        end
      end
      WAIT_HIGH: begin
        // The rise cycle is the first high cycle, so the count equals pulse width.
        if (rise) begin
          hi_d    = 8'd1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          lo_d    = 8'd1;
          state_d = LOW;
          if (hi_q < MIN_H) begin
            err_timing_d = 1'b1;
          end else if (hi_q > MAX_H) begin
            err_timing_d = 1'b1;
            abort        = 1'b1;
          end else begin
            bit_vld = 1'b1;
            bit_val = (hi_q >= ONE_T);
          end
        end else begin
          hi_d = sat_inc8(hi_q);
        end
      end
      LOW: begin
        // End of frame wins over a rise landing on the same cycle.
        if (lo_inc >= RST_LO) begin
          lo_d    = '0;
          state_d = FLUSH;
        end else if (rise) begin
          hi_d    = 8'd1;
          state_d = HIGH;
        end else begin
          lo_d = lo_inc;
        end
      end
      FLUSH: begin
        if (!byte_idx_q[0] || can_push) begin
          if (byte_idx_q[0]) begin
            push            = 1'b1;
            push_word.wdata = {8'h00, lo_byte_q};
            push_word.sel   = 2'b01;
          end
          frame_bytes_d = byte_idx_q;
          frame_done_d  = 1'b1;
          byte_idx_d    = '0;
          bitcnt_d      = '0;
          state_d       = WAIT_HIGH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bit_vld) begin
      byte_val = {shreg_q, bit_val};
      shreg_d  = {shreg_q[5:0], bit_val};
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7 && byte_idx_q < MAX_B) begin
        if (byte_idx_q[0]) begin
          push            = 1'b1;
          push_word.wdata = {byte_val, lo_byte_q};
        end else begin
          lo_byte_d = byte_val;
        end
        byte_idx_d = byte_idx_q + 9'd1;
      end
    end

    if (abort || !enable) begin
      state_d      = IDLE;
      lo_d         = '0;
      bitcnt_d     = '0;
      byte_idx_d   = '0;
      push         = 1'b0;
      frame_done_d = 1'b0;
      if (!enable) err_timing_d = err_timing_q;
    end
  end

  // One outstanding write plus one holding slot; req drops for a cycle after each ack.
  assign ack_fire  = m_a_ack & req_q;
  assign slot_free = ~out_vld_q | ack_fire;
  assign can_push  = ~(out_vld_q & ~ack_fire & hold_vld_q);

  always_comb begin
    out_vld_d     = out_vld_q;
    out_d         = out_q;
    hold_vld_d    = hold_vld_q;
    hold_d        = hold_q;
    err_overrun_d = err_overrun_q;
    if (slot_free) begin
      if (hold_vld_q) begin
        out_d      = hold_q;
        out_vld_d  = 1'b1;
        hold_vld_d = push;
        hold_d     = push_word;
      end else if (push) begin
        out_d     = push_word;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (push) begin
      if (!hold_vld_q) begin
        hold_d     = push_word;
        hold_vld_d = 1'b1;
      end else begin
        err_overrun_d = 1'b1;
      end
    end
    req_d = out_vld_d & ~ack_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      bitcnt_q      <= '0;
      byte_idx_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_bytes_q <= '0;
      err_timing_q  <= 1'b0;
      err_overrun_q <= 1'b0;
      out_vld_q     <= 1'b0;
      req_q         <= 1'b0;
      hold_vld_q    <= 1'b0;
      out_q         <= '{adr: BASE, wdata: 16'h0000, sel: 2'b11};
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      bitcnt_q      <= bitcnt_d;
      byte_idx_q    <= byte_idx_d;
      frame_done_q  <= frame_done_d;
      frame_bytes_q <= frame_bytes_d;
      err_timing_q  <= err_timing_d;
      err_overrun_q <= err_overrun_d;
      out_vld_q     <= out_vld_d;
      req_q         <= req_d;
      hold_vld_q    <= hold_vld_d;
      out_q         <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q   <= shreg_d;
    lo_byte_q <= lo_byte_d;
    hold_q    <= hold_d;
  end

  logic unused_rdata;
  assign unused_rdata = ^m_a_rdata;

  assign m_a_req     = req_q;
  assign m_a_adr     = out_q.adr;
  assign m_a_wdata   = out_q.wdata;
  assign m_a_sel     = out_q.sel;
  assign m_a_write   = 1'b1;
  assign frame_done  = frame_done_q;
  assign frame_bytes = frame_bytes_q;
  assign err_overrun = err_overrun_q;
  assign err_timing  = err_timing_q;

endmodule

// File: tb/tb_lights_receiver.sv
// Scoreboard bench for lights_receiver: frames in, expected bus writes queued and matched on ack.
module tb_lights_receiver;
  import lights_pkg::*;

  localparam int BASE = 500;
  localparam int MAXB = 300;

  logic        clk = 1'b0;
  logic        rst, enable, din, m_a_ack;
  logic [17:0] m_a_adr;
  logic        m_a_req, m_a_write, frame_done, err_overrun, err_timing;
  logic [1:0]  m_a_sel;
  logic [15:0] m_a_rdata, m_a_wdata;
  logic [8:0]  frame_bytes;

  int          errors = 0;
  int          checks = 0;
  wr_word_t    exp_q[$];
  logic [7:0]  fb[$];
  logic        ack_hold = 1'b0;
  logic [17:0] last_adr = '0;

  always #5 clk = ~clk;

  lights_receiver dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .din         (din),
    .m_a_adr     (m_a_adr),
    .m_a_req     (m_a_req),
    .m_a_ack     (m_a_ack),
    .m_a_write   (m_a_write),
    .m_a_sel     (m_a_sel),
    .m_a_rdata   (m_a_rdata),
    .m_a_wdata   (m_a_wdata),
    .frame_done  (frame_done),
    .frame_bytes (frame_bytes),
    .err_overrun (err_overrun),
    .err_timing  (err_timing)
  );

  // Bus responder: single-cycle ack, each accepted write popped from the scoreboard.
  initial begin
    wr_word_t got, want;
    m_a_ack   = 1'b0;
    m_a_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      m_a_ack = 1'b0;
      if (rst === 1'b0 && m_a_req === 1'b1 && !ack_hold) begin
        got = '{adr: m_a_adr, wdata: m_a_wdata, sel: m_a_sel};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got adr=%0d wdata=%h sel=%b, required no write",
                   got.adr, got.wdata, got.sel);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL write: got adr=%0d wdata=%h sel=%b, required adr=%0d wdata=%h sel=%b",
                     got.adr, got.wdata, got.sel, want.adr, want.wdata, want.sel);
          end
        end
        last_adr = m_a_adr;
        m_a_ack  = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_bit(input logic b, input logic spike);
    int h;
    h = b ? int'(T1H) : int'(T0H);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    if (spike) begin
      repeat (4) @(negedge clk);
      din = 1'b1;
      @(negedge clk);
      din = 1'b0;
      repeat (int'(BIT_CYCLES) - h - 5) @(negedge clk);
    end else begin
      repeat (int'(BIT_CYCLES) - h) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int spike_bit);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == spike_bit);
  endtask

  task automatic send_frame(input int spike_byte, input int spike_bit);
    for (int k = 0; k < fb.size(); k++) send_byte(fb[k], (k == spike_byte) ? spike_bit : -1);
  endtask

  task automatic send_low(input int n, output int pulses);
    din    = 1'b0;
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (frame_done === 1'b1) pulses++;
    end
  endtask

  // Pair bytes into words (low byte first), cap at MAXB bytes, trailing odd byte with sel 01.
  task automatic expect_writes(input int keep_words);
    int nb, words;
    wr_word_t w;
    nb    = (fb.size() < MAXB) ? fb.size() : MAXB;
    words = 0;
    for (int i = 1; i < nb; i += 2) begin
      if (words < keep_words) begin
        w.adr   = 18'(BASE + i / 2);
        w.wdata = {fb[i], fb[i-1]};
        w.sel   = 2'b11;
        exp_q.push_back(w);
        words++;
      end
    end
    if (nb % 2 == 1) begin
      w.adr   = 18'(BASE + nb / 2);
      w.wdata = {8'h00, fb[nb-1]};
      w.sel   = 2'b01;
      exp_q.push_back(w);
    end
  endtask

  task automatic wait_drain(output int remaining);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_a_req === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    remaining = exp_q.size();
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (m_a_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", m_a_req); end
    checks++; if (m_a_adr !== 18'd500) begin errors++; $display("FAIL reset_adr: got %0d, required 500", m_a_adr); end
    checks++; if (m_a_sel !== 2'b11) begin errors++; $display("FAIL reset_sel: got %b, required 11", m_a_sel); end
    checks++; if (m_a_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h, required 0000", m_a_wdata); end
    checks++; if (m_a_write !== 1'b1) begin errors++; $display("FAIL reset_write: got %b, required 1", m_a_write); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", frame_done); end
    checks++; if (frame_bytes !== 9'd0) begin errors++; $display("FAIL reset_bytes: got %0d, required 0", frame_bytes); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", err_overrun); end
    checks++; if (err_timing !== 1'b0) begin errors++; $display("FAIL reset_timing: got %b, required 0", err_timing); end
  endtask

  task automatic test_two_bytes();
    int p, rem;
    send_low(120, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL idle_no_done: got %0d pulses, required 0", p); end
    fb = '{8'hA5, 8'h3C};
    expect_writes(1000);
    send_frame(-1, -1);
    send_low(120, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL two_done: got %0d pulses, required 1", p); end
    checks++; if (frame_bytes !== 9'd2) begin errors++; $display("FAIL two_bytes: got %0d, required 2", frame_bytes); end
    wait_drain(rem);
    checks++; if (rem !== 0) begin errors++; $display("FAIL two_drain: got %0d pending, required 0", rem); end
    checks++; if (err_timing !== 1'b0) begin errors++; $display("FAIL two_timing: got %b, required 0", err_timing); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL two_overrun: got %b, required 0", err_overrun); end
  endtask

  task automatic test_odd_flush();
    int p, rem;
    fb = '{8'h01, 8'h02, 8'h03};
    expect_writes(1000);
    send_frame(-1, -1);
    send_low(120, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL odd_done: got %0d pulses, required 1", p); end
    checks++; if (frame_bytes !== 9'd3) begin errors++; $display("FAIL odd_bytes: got %0d, required 3", frame_bytes); end
    wait_drain(rem);
    checks++; if (rem !== 0) begin errors++; $display("FAIL odd_drain: got %0d pending, required 0", rem); end
  endtask

  task automatic test_max_bytes();
    int p, rem;
    fb.delete();
    for (int k = 0; k < 302; k++) fb.push_back(8'((k * 37 + 11) & 255));
    expect_writes(1000);
    send_frame(-1, -1);
    send_low(120, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL max_done: got %0d pulses, required 1", p); end
    checks++; if (frame_bytes !== 9'd300) begin errors++; $display("FAIL max_bytes: got %0d, required 300", frame_bytes); end
    wait_drain(rem);
    checks++; if (rem !== 0) begin errors++; $display("FAIL max_drain: got %0d pending, required 0", rem); end
    checks++; if (last_adr !== 18'd649) begin errors++; $display("FAIL max_last_adr: got %0d, required 649", last_adr); end
  endtask

  task automatic test_overrun();
    int p, rem;
    ack_hold = 1'b1;
    fb = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    expect_writes(2);
    send_frame(-1, -1);
    send_low(120, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL ovr_done: got %0d pulses, required 1", p); end
    checks++; if (frame_bytes !== 9'd6) begin errors++; $display("FAIL ovr_bytes: got %0d, required 6", frame_bytes); end
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b, required 1", err_overrun); end
    checks++; if (m_a_req !== 1'b1) begin errors++; $display("FAIL ovr_req_held: got %b, required 1", m_a_req); end
    checks++; if (m_a_adr !== 18'd500) begin errors++; $display("FAIL ovr_adr_held: got %0d, required 500", m_a_adr); end
    checks++; if (m_a_wdata !== 16'h2010) begin errors++; $display("FAIL ovr_wdata_held: got %h, required 2010", m_a_wdata); end
    ack_hold = 1'b0;
    wait_drain(rem);
    checks++; if (rem !== 0) begin errors++; $display("FAIL ovr_drain: got %0d pending, required 0", rem); end
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b, required 1", err_overrun); end
  endtask

  task automatic test_glitch();
    int p, rem;
    logic exp_t;
`ifdef LIGHTS_RX_GLITCH_FILTER_EN
    exp_t = 1'b0;
`else
    exp_t = 1'b1;
`endif
    fb = '{8'h5A, 8'hC3};
    expect_writes(1000);
    send_frame(0, 2);
    send_low(120, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL glitch_done: got %0d pulses, required 1", p); end
    checks++; if (frame_bytes !== 9'd2) begin errors++; $display("FAIL glitch_bytes: got %0d, required 2", frame_bytes); end
    checks++; if (err_timing !== exp_t) begin errors++; $display("FAIL glitch_timing: got %b, required %b", err_timing, exp_t); end
    wait_drain(rem);
    checks++; if (rem !== 0) begin errors++; $display("FAIL glitch_drain: got %0d pending, required 0", rem); end
  endtask

  task automatic test_mid_reset();
    int p, rem, n;
    ack_hold = 1'b1;
    fb = '{8'h11, 8'h22};
    send_frame(-1, -1);
    n = 0;
    while (m_a_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (m_a_req !== 1'b1) begin errors++; $display("FAIL mid_req_up: got %b, required 1", m_a_req); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (m_a_req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b, required 0", m_a_req); end
    checks++; if (m_a_adr !== 18'd500) begin errors++; $display("FAIL mid_adr: got %0d, required 500", m_a_adr); end
    checks++; if (m_a_sel !== 2'b11) begin errors++; $display("FAIL mid_sel: got %b, required 11", m_a_sel); end
    checks++; if (m_a_wdata !== 16'h0) begin errors++; $display("FAIL mid_wdata: got %h, required 0000", m_a_wdata); end
    checks++; if (frame_bytes !== 9'd0) begin errors++; $display("FAIL mid_bytes: got %0d, required 0", frame_bytes); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b, required 0", err_overrun); end
    checks++; if (err_timing !== 1'b0) begin errors++; $display("FAIL mid_timing: got %b, required 0", err_timing); end
    rst = 1'b0;
    exp_q.delete();
    ack_hold = 1'b0;
    send_byte(8'hFF, -1);
    send_low(120, p);
    checks++; if (p !== 0) begin errors++; $display("FAIL rearm_no_done: got %0d pulses, required 0", p); end
    fb = '{8'h77, 8'h88};
    expect_writes(1000);
    send_frame(-1, -1);
    send_low(120, p);
    checks++; if (p !== 1) begin errors++; $display("FAIL rearm_done: got %0d pulses, required 1", p); end
    checks++; if (frame_bytes !== 9'd2) begin errors++; $display("FAIL rearm_bytes: got %0d, required 2", frame_bytes); end
    wait_drain(rem);
    checks++; if (rem !== 0) begin errors++; $display("FAIL rearm_drain: got %0d pending, required 0", rem); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; din = 1'b0;
    @(negedge clk);
    test_reset();
    test_two_bytes();
    test_odd_flush();
    test_max_bytes();
    test_overrun();
    test_glitch();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
